// File: rtl/dmem_responder.sv
// Data-memory responder: masked word writes commit on accept, reads return after READ_LAT cycles.
// Busy during the READ_LAT-1 wait cycles (requests then ignored); DMEM_STATS_EN adds event counters.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          READ_LAT    = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [3:0]  i_dmem_mask,
  input  logic [31:0] i_dmem_wdata,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_rvld,
  output logic        o_dmem_busy,
  output logic        o_dmem_err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] o_rd_cnt,
  output logic [31:0] o_wr_cnt,
  output logic [15:0] o_err_cnt
`endif
);

  localparam int          IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;
  localparam logic [1:0]  LAT_M1 = 2'(READ_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       rd_hold;
  logic [32:0]       off;
  logic [IDX_W-1:0]  idx;
  logic              in_range, accept, bad, rd_acc, wr_acc, err_set, resp_go;

  // A borrow out of the 33-bit subtract lands above SPAN, so below-base is out of range too.
  assign off      = {1'b0, i_dmem_addr} - {1'b0, BASE_ADDR};
  assign in_range = (off < SPAN);
  assign idx      = off[IDX_W+1:2];

  assign o_dmem_busy = (state == S_WAIT);
  assign accept      = (i_dmem_ren | i_dmem_wen) & ~o_dmem_busy & ~i_rst;
  assign bad         = (i_dmem_ren & i_dmem_wen) | ~in_range;
  assign rd_acc      = accept & i_dmem_ren & ~bad;
  assign wr_acc      = accept & i_dmem_wen & ~bad;
  assign err_set     = accept & bad;
  assign resp_go     = (state == S_WAIT) && (cnt == 2'd1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE, S_RESP: begin
        state_nxt = S_IDLE;
        if (rd_acc && (READ_LAT > 1)) begin
          state_nxt = S_WAIT;
          cnt_nxt   = LAT_M1;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 2'd1;
        if (cnt == 2'd1) state_nxt = S_RESP;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      cnt          <= 2'd0;
      o_dmem_rvld  <= 1'b0;
      o_dmem_rdata <= 32'd0;
      o_dmem_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      o_dmem_err <= err_set;
      if (READ_LAT == 1) begin
        o_dmem_rvld <= rd_acc;
        if (rd_acc) o_dmem_rdata <= mem[idx];
      end else begin
        o_dmem_rvld <= resp_go;
        if (resp_go) o_dmem_rdata <= rd_hold;
      end
    end
  end

  // Array and the captured read word carry no reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      for (int b = 0; b < 4; b++) begin
        if (i_dmem_mask[b]) mem[idx][8*b +: 8] <= i_dmem_wdata[8*b +: 8];
      end
    end
    if (rd_acc) rd_hold <= mem[idx];
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_cnt  <= 32'd0;
      o_wr_cnt  <= 32'd0;
      o_err_cnt <= 16'd0;
    end else begin
      if (rd_acc) o_rd_cnt <= o_rd_cnt + 32'd1;
      if (wr_acc) o_wr_cnt <= o_wr_cnt + 32'd1;
      if (err_set && (o_err_cnt != 16'hFFFF)) o_err_cnt <= o_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at READ_LAT 1, 2 and 3 (instances share one request bus).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'd0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [3:0]  mask = 4'd0;
  logic [31:0] wdata = 32'd0;

  logic [31:0] rdata [3];
  logic [2:0]  rvld, busy, err;
`ifdef DMEM_STATS_EN
  logic [31:0] rd_cnt [3];
  logic [31:0] wr_cnt [3];
  logic [15:0] err_cnt [3];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(.DEPTH_WORDS(1024), .READ_LAT(g + 1), .BASE_ADDR(32'h0)) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_dmem_addr  (addr),
      .i_dmem_ren   (ren),
      .i_dmem_wen   (wen),
      .i_dmem_mask  (mask),
      .i_dmem_wdata (wdata),
      .o_dmem_rdata (rdata[g]),
      .o_dmem_rvld  (rvld[g]),
      .o_dmem_busy  (busy[g]),
      .o_dmem_err   (err[g])
`ifdef DMEM_STATS_EN
      ,
      .o_rd_cnt     (rd_cnt[g]),
      .o_wr_cnt     (wr_cnt[g]),
      .o_err_cnt    (err_cnt[g])
`endif
    );
  end

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        e_rvld;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive one request at the falling edge, then sample just after the next rising edge.
  task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                     input logic [3:0] m, input logic [31:0] d);
    @(negedge clk);
    ren = r; wen = w; addr = a; mask = m; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 32'h10,       4'hF, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h10,       4'h0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'h20,       4'hF, 32'hAABBCCDD, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 32'h20,       4'h5, 32'h11223344, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h20,       4'h0, 32'h0,        1'b1, 32'hAA22CC44, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h10,       4'h0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 32'h10,       4'hF, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 32'h1000,     4'h0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h10,       4'h0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 32'h10,       4'h0, 32'hFFFFFFFF, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 32'h10,       4'h0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 32'hFFC,      4'hF, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 32'hFFC,      4'h0, 32'h0,        1'b1, 32'h12345678, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 32'h23,       4'h0, 32'h0,        1'b1, 32'hAA22CC44, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 32'h1000,     4'hF, 32'h55555555, 1'b0, 32'hAA22CC44, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 32'hFFFFFFFC, 4'h0, 32'h0,        1'b0, 32'hAA22CC44, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 32'hAA22CC44, 1'b0};

    // Reset state of every instance
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst%0d rdata", g), rdata[g], 32'h0);
      chk($sformatf("rst%0d rvld", g), 32'(rvld[g]), 32'h0);
      chk($sformatf("rst%0d busy", g), 32'(busy[g]), 32'h0);
      chk($sformatf("rst%0d err", g), 32'(err[g]), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // READ_LAT=1 table: each row's response is visible right after its accepting edge
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].mask, tbl[i].wdata);
      chk($sformatf("l1 row%0d rvld", i), 32'(rvld[0]), 32'(tbl[i].e_rvld));
      chk($sformatf("l1 row%0d rdata", i), rdata[0], tbl[i].e_rdata);
      chk($sformatf("l1 row%0d err", i), 32'(err[0]), 32'(tbl[i].e_err));
      chk($sformatf("l1 row%0d busy", i), 32'(busy[0]), 32'h0);
    end

    // READ_LAT=3: busy two cycles, write during busy ignored, new read accepted in RESP
    idle(6);
    cyc(1'b0, 1'b1, 32'h40, 4'hF, 32'h0BADF00D);
    cyc(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
    chk("l3 busy T+1", 32'(busy[2]), 32'h1);
    chk("l3 rvld T+1", 32'(rvld[2]), 32'h0);
    cyc(1'b0, 1'b1, 32'h40, 4'hF, 32'hFFFFFFFF);
    chk("l3 busy T+2", 32'(busy[2]), 32'h1);
    chk("l3 rvld T+2", 32'(rvld[2]), 32'h0);
    chk("l3 err on busy write", 32'(err[2]), 32'h0);
    idle(1);
    chk("l3 busy T+3", 32'(busy[2]), 32'h0);
    chk("l3 rvld T+3", 32'(rvld[2]), 32'h1);
    chk("l3 rdata T+3", rdata[2], 32'h0BADF00D);
    cyc(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
    chk("l3 back-to-back accept busy", 32'(busy[2]), 32'h1);
    chk("l3 rdata hold", rdata[2], 32'h0BADF00D);
    idle(1);
    chk("l3 second busy", 32'(busy[2]), 32'h1);
    idle(1);
    chk("l3 second rvld", 32'(rvld[2]), 32'h1);
    chk("l3 ignored write left array", rdata[2], 32'h0BADF00D);
    idle(1);
    chk("l3 rvld single pulse", 32'(rvld[2]), 32'h0);

    // READ_LAT=2: reset during the wait cycle discards the read
    idle(4);
    cyc(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
    chk("l2 busy", 32'(busy[1]), 32'h1);
    idle(1);
    chk("l2 rvld", 32'(rvld[1]), 32'h1);
    chk("l2 rdata", rdata[1], 32'h0BADF00D);
    cyc(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
    chk("l2 busy before rst", 32'(busy[1]), 32'h1);
    rst = 1'b1;
    idle(1);
    chk("l2 rst busy", 32'(busy[1]), 32'h0);
    chk("l2 rst rdata", rdata[1], 32'h0);
    chk("l2 rst no rvld", 32'(rvld[1]), 32'h0);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
    chk("l2 post-rst busy", 32'(busy[1]), 32'h1);
    chk("l2 post-rst no stale rvld", 32'(rvld[1]), 32'h0);
    idle(1);
    chk("l2 post-rst rvld", 32'(rvld[1]), 32'h1);
    chk("l2 post-rst rdata", rdata[1], 32'h0BADF00D);

`ifdef DMEM_STATS_EN
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("stats rd after rst", rd_cnt[0], 32'h0);
    chk("stats wr after rst", wr_cnt[0], 32'h0);
    chk("stats err after rst", 32'(err_cnt[0]), 32'h0);
    cyc(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    cyc(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    cyc(1'b0, 1'b1, 32'h20, 4'h0, 32'h0);
    cyc(1'b1, 1'b1, 32'h10, 4'hF, 32'h0);
    idle(1);
    chk("stats rd", rd_cnt[0], 32'd3);
    chk("stats wr", wr_cnt[0], 32'd2);
    chk("stats err", 32'(err_cnt[0]), 32'd1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("stats rd cleared", rd_cnt[0], 32'h0);
    chk("stats wr cleared", wr_cnt[0], 32'h0);
    chk("stats err cleared", 32'(err_cnt[0]), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
